gmii_rx_frame_parser: RTL

// - Consumes the GMII receive stream produced by the PCS/PMA (gmii_rxd/rx_dv/rx_er), downstream of the 8b10b decoder.
// - Strips the preamble and SFD, checks the CRC-32 FCS and frame length, removes the 4 FCS bytes, and emits the

---
 rtl/gmii_rx_frame_parser_pkg.sv | 29 ++
 rtl/gmii_rx_frame_parser_if.sv | 25 ++
 rtl/gmii_rx_frame_parser_crc32_d8.sv | 19 +
 rtl/gmii_rx_frame_parser.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/gmii_rx_frame_parser_pkg.sv
// Shared Ethernet receive constants, FSM state type and CRC helpers.
// Used by the GMII frame parser and reusable by the transmit side.
package eth_rx_pkg;

   localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
   localparam logic [7:0]  SFD_BYTE      = 8'hD5;
   localparam logic [31:0] CRC_INIT      = 32'hFFFFFFFF;
   localparam logic [31:0] CRC_RESIDUE   = 32'hC704DD7B;
   localparam logic [31:0] CRC_POLY      = 32'hEDB88320;
   localparam int          DELAY_STAGES  = 5;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_PREAMBLE,
      ST_DATA,
      ST_DROP
   } rx_state_t;

   // The residue constant is in normal bit order; the reflected CRC register
   // must be bit-reversed before comparing against it.
   function automatic logic [31:0] bit_reverse32(input logic [31:0] value);
      logic [31:0] result;
      for (int i = 0; i < 32; i++) begin
         result[i] = value[31 - i];
      end
      return result;
   endfunction

endpackage

// File: rtl/gmii_rx_frame_parser_if.sv
// GMII receive input plus parsed payload stream, bundled for the frame parser.
// master drives the GMII side and consumes the payload; slave is the parser.
interface gmii_rx_frame_parser_if;

   logic [7:0]  gmii_rxd;
   logic        gmii_rx_dv;
   logic        gmii_rx_er;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_sof;
   logic        out_eof;
   logic        out_err;
   logic [10:0] out_len;

   modport master (
      output gmii_rxd, gmii_rx_dv, gmii_rx_er,
      input  out_data, out_valid, out_sof, out_eof, out_err, out_len
   );

   modport slave (
      input  gmii_rxd, gmii_rx_dv, gmii_rx_er,
      output out_data, out_valid, out_sof, out_eof, out_err, out_len
   );

endinterface

// File: rtl/gmii_rx_frame_parser_crc32_d8.sv
// Combinational IEEE 802.3 CRC-32 step, reflected, one byte per call.
module crc32_d8
   import eth_rx_pkg::*;
(
   input  logic [31:0] crc_in,
   input  logic [7:0]  data,
   output logic [31:0] crc_out
);

   always_comb begin
      logic [31:0] c;
      c = crc_in ^ {24'h0, data};
      for (int i = 0; i < 8; i++) begin
         c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
      end
      crc_out = c;
   end

endmodule

// File: rtl/gmii_rx_frame_parser.sv
// GMII receive frame parser: strips preamble/SFD, checks FCS and length,
// and streams the payload through a 5-byte delay line so the FCS never leaves.
module gmii_rx_frame_parser
   import eth_rx_pkg::*;
#(
   parameter int MIN_FRAME = 64,
   parameter int MAX_FRAME = 1518
) (
   input  logic                  clock,
   input  logic                  reset,
   gmii_rx_frame_parser_if.slave rx,
   output logic [15:0]           frames_ok,
   output logic [15:0]           frames_bad
);

   localparam logic [10:0] MIN_LEN   = 11'(MIN_FRAME);
   localparam logic [10:0] MAX_LEN   = 11'(MAX_FRAME);
   localparam logic [10:0] COUNT_SAT = 11'h7FF;
   localparam int          LAST      = DELAY_STAGES - 1;

   rx_state_t               state_reg, state_next;
   logic [31:0]             crc_reg, crc_next;
   logic [10:0]             count_reg;
   logic                    err_reg;
   logic                    sof_pending_reg;
   logic [7:0]              pipe_data_reg [DELAY_STAGES];
   logic [DELAY_STAGES-1:0] pipe_valid_reg;
   logic                    frame_start, data_byte, frame_end, frame_bad;

   crc32_d8 u_crc (
      .crc_in  (crc_reg),
      .data    (rx.gmii_rxd),
      .crc_out (crc_next)
   );

   always_ff @(posedge clock or posedge reset) begin
      if (reset) state_reg <= ST_IDLE;
      else       state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (rx.gmii_rx_dv)
               state_next = (rx.gmii_rxd == PREAMBLE_BYTE) ? ST_PREAMBLE : ST_DROP;
         end
         ST_PREAMBLE: begin
            if (!rx.gmii_rx_dv)                   state_next = ST_IDLE;
            else if (rx.gmii_rx_er)               state_next = ST_DROP;
            else if (rx.gmii_rxd == PREAMBLE_BYTE) state_next = ST_PREAMBLE;
            else if (rx.gmii_rxd == SFD_BYTE)      state_next = ST_DATA;
            else                                   state_next = ST_DROP;
         end
         ST_DATA: if (!rx.gmii_rx_dv) state_next = ST_IDLE;
         ST_DROP: if (!rx.gmii_rx_dv) state_next = ST_IDLE;
         default: state_next = ST_IDLE;
      endcase
   end

   always_comb begin
      frame_start = 1'b0;
      data_byte   = 1'b0;
      frame_end   = 1'b0;
      case (state_reg)
         ST_PREAMBLE: frame_start = rx.gmii_rx_dv && !rx.gmii_rx_er && (rx.gmii_rxd == SFD_BYTE);
         ST_DATA: begin
            data_byte = rx.gmii_rx_dv;
            frame_end = !rx.gmii_rx_dv;
         end
         default: ;
      endcase
   end

   // An empty last stage at frame end means a runt of 4 bytes or fewer.
   assign frame_bad = (bit_reverse32(crc_reg) != CRC_RESIDUE) ||
                      (count_reg < MIN_LEN) || (count_reg > MAX_LEN) ||
                      err_reg || !pipe_valid_reg[LAST];

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < DELAY_STAGES; i++) pipe_data_reg[i] <= '0;
         pipe_valid_reg <= '0;
      end else if (frame_start || frame_end) begin
         pipe_valid_reg <= '0;
      end else if (data_byte) begin
         pipe_data_reg[0] <= rx.gmii_rxd;
         for (int i = 1; i < DELAY_STAGES; i++) pipe_data_reg[i] <= pipe_data_reg[i-1];
         pipe_valid_reg <= {pipe_valid_reg[DELAY_STAGES-2:0], 1'b1};
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         crc_reg         <= CRC_INIT;
         count_reg       <= '0;
         err_reg         <= 1'b0;
         sof_pending_reg <= 1'b0;
         rx.out_data     <= '0;
         rx.out_valid    <= 1'b0;
         rx.out_sof      <= 1'b0;
         rx.out_eof      <= 1'b0;
         rx.out_err      <= 1'b0;
         rx.out_len      <= '0;
         frames_ok       <= '0;
         frames_bad      <= '0;
      end else begin
         rx.out_valid <= 1'b0;
         rx.out_sof   <= 1'b0;
         rx.out_eof   <= 1'b0;
         rx.out_err   <= 1'b0;
         rx.out_len   <= '0;
         if (frame_start) begin
            crc_reg         <= CRC_INIT;
            count_reg       <= '0;
            err_reg         <= 1'b0;
            sof_pending_reg <= 1'b1;
         end
         if (data_byte) begin
            crc_reg <= crc_next;
            if (count_reg != COUNT_SAT) count_reg <= count_reg + 11'd1;
            if (rx.gmii_rx_er)          err_reg   <= 1'b1;
         end
         if ((data_byte || frame_end) && pipe_valid_reg[LAST]) begin
            rx.out_data     <= pipe_data_reg[LAST];
            rx.out_valid    <= 1'b1;
            rx.out_sof      <= sof_pending_reg;
            sof_pending_reg <= 1'b0;
            rx.out_eof      <= frame_end;
            rx.out_err      <= frame_end && frame_bad;
            rx.out_len      <= frame_end ? (count_reg - 11'd4) : 11'd0;
         end
         if (frame_end) begin
            sof_pending_reg <= 1'b0;
            if (frame_bad) frames_bad <= frames_bad + 16'd1;
            else           frames_ok  <= frames_ok + 16'd1;
         end
      end
   end

endmodule
